// File: rtl/wb_regfile.sv
// Writeback stage and register file: commits the EX-to-WB result into the array
// and serves two combinational read ports that bypass the x1 and x2 results.
module wb_regfile #(
    parameter int NUM_REGS = 16,
    parameter int ADRS_W   = 4,
    parameter int DATA_W   = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_enx1,
    input  logic [ADRS_W-1:0] dstx1,
    input  logic [DATA_W-1:0] dataoutx1,
    input  logic              wr_enx2,
    input  logic [ADRS_W-1:0] dstx2,
    input  logic [DATA_W-1:0] dataoutx2,
    input  logic [ADRS_W-1:0] rd_adrs_a,
    input  logic [ADRS_W-1:0] rd_adrs_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [15:0]       wb_count
);

    localparam logic [1:0] SEL_ARRAY = 2'd0;
    localparam logic [1:0] SEL_X2    = 2'd1;
    localparam logic [1:0] SEL_X1    = 2'd2;
    localparam logic [1:0] SEL_ZERO  = 2'd3;

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    logic [15:0]       wb_count_q;
    logic [15:0]       wb_count_d;
    logic              commit;

    assign commit = wr_enx2 && (dstx2 != '0);

    always_comb begin
        rf_d       = rf_q;
        wb_count_d = wb_count_q;
        if (commit) begin
            rf_d[dstx2] = dataoutx2;
            if (wb_count_q != 16'hFFFF) begin
                wb_count_d = wb_count_q + 16'd1;
            end
        end
        // Entry 0 is hardwired; pinning it here keeps the flop constant.
        rf_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            rf_q       <= rf_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

    // Returns {fwd_sel, data}; the younger x1 result outranks x2.
    function automatic logic [DATA_W+1:0] resolve(
        input logic              rstn,
        input logic [ADRS_W-1:0] adrs,
        input logic [DATA_W-1:0] arrayData,
        input logic              en1,
        input logic [ADRS_W-1:0] dst1,
        input logic [DATA_W-1:0] data1,
        input logic              en2,
        input logic [ADRS_W-1:0] dst2,
        input logic [DATA_W-1:0] data2
    );
        logic [DATA_W+1:0] result;
        result = {SEL_ARRAY, arrayData};
        if (!rstn || adrs == '0) begin
            result = {SEL_ZERO, {DATA_W{1'b0}}};
        end else if (en1 && dst1 == adrs) begin
            result = {SEL_X1, data1};
        end else if (en2 && dst2 == adrs) begin
            result = {SEL_X2, data2};
        end
        return result;
    endfunction

    always_comb begin
        {fwd_sel_a, rd_data_a} = resolve(resetn, rd_adrs_a, rf_q[rd_adrs_a],
                                         wr_enx1, dstx1, dataoutx1,
                                         wr_enx2, dstx2, dataoutx2);
        {fwd_sel_b, rd_data_b} = resolve(resetn, rd_adrs_b, rf_q[rd_adrs_b],
                                         wr_enx1, dstx1, dataoutx1,
                                         wr_enx2, dstx2, dataoutx2);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Table-driven bench for wb_regfile: each vector is checked just before its
// rising edge, then hand-written sequences cover the commit counter saturation.
module tb_wb_regfile;

    logic        clock;
    logic        resetn;
    logic        wr_enx1;
    logic [3:0]  dstx1;
    logic [15:0] dataoutx1;
    logic        wr_enx2;
    logic [3:0]  dstx2;
    logic [15:0] dataoutx2;
    logic [3:0]  rd_adrs_a;
    logic [3:0]  rd_adrs_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] wb_count;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic        resetn;
        logic        wrEnx1;
        logic [3:0]  dstx1;
        logic [15:0] dataX1;
        logic        wrEnx2;
        logic [3:0]  dstx2;
        logic [15:0] dataX2;
        logic [3:0]  adrsA;
        logic [3:0]  adrsB;
        logic [15:0] expA;
        logic [1:0]  expSelA;
        logic [15:0] expB;
        logic [1:0]  expSelB;
        logic [15:0] expCount;
    } vec_t;

    vec_t vecs [15];

    wb_regfile #(.NUM_REGS(16), .ADRS_W(4), .DATA_W(16)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .wr_enx1   (wr_enx1),
        .dstx1     (dstx1),
        .dataoutx1 (dataoutx1),
        .wr_enx2   (wr_enx2),
        .dstx2     (dstx2),
        .dataoutx2 (dataoutx2),
        .rd_adrs_a (rd_adrs_a),
        .rd_adrs_b (rd_adrs_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .fwd_sel_a (fwd_sel_a),
        .fwd_sel_b (fwd_sel_b),
        .wb_count  (wb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input vec_t v);
        resetn    = v.resetn;
        wr_enx1   = v.wrEnx1;
        dstx1     = v.dstx1;
        dataoutx1 = v.dataX1;
        wr_enx2   = v.wrEnx2;
        dstx2     = v.dstx2;
        dataoutx2 = v.dataX2;
        rd_adrs_a = v.adrsA;
        rd_adrs_b = v.adrsB;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s (step %0d): actual %h required %h", name, idx, actual, expected);
        end
    endtask

    task automatic commitOnce(input logic [3:0] dst, input logic [15:0] data);
        @(negedge clock);
        resetn    = 1'b1;
        wr_enx1   = 1'b0;
        wr_enx2   = 1'b1;
        dstx2     = dst;
        dataoutx2 = data;
    endtask

    initial begin
        //            rstn x1en dst1  data1     x2en dst2  data2     A     B     expA      sA    expB      sB    count
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  16'h1234, 4'd3,  4'd0,  16'h1234, 2'd1, 16'h0000, 2'd3, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'd3,  16'h5555, 1'b1, 4'd5,  16'hAAAA, 4'd3,  4'd5,  16'h0000, 2'd3, 16'h0000, 2'd3, 16'd1};
        vecs[2]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd3,  4'd5,  16'h0000, 2'd0, 16'h0000, 2'd0, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd7,  16'hBEEF, 4'd7,  4'd7,  16'hBEEF, 2'd1, 16'hBEEF, 2'd1, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd7,  4'd3,  16'hBEEF, 2'd0, 16'h0000, 2'd0, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 4'd0,  16'h1111, 1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd0,  16'h0000, 2'd3, 16'h0000, 2'd3, 16'd1};
        vecs[6]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd2,  16'h0001, 4'd2,  4'd0,  16'h0001, 2'd1, 16'h0000, 2'd3, 16'd1};
        vecs[7]  = '{1'b1, 1'b1, 4'd2,  16'h0003, 1'b1, 4'd2,  16'h0002, 4'd2,  4'd2,  16'h0003, 2'd2, 16'h0003, 2'd2, 16'd2};
        vecs[8]  = '{1'b1, 1'b0, 4'd2,  16'h0003, 1'b0, 4'd0,  16'h0000, 4'd2,  4'd7,  16'h0002, 2'd0, 16'hBEEF, 2'd0, 16'd3};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd4,  16'h0044, 4'd4,  4'd1,  16'h0044, 2'd1, 16'h0000, 2'd0, 16'd3};
        vecs[10] = '{1'b1, 1'b0, 4'd4,  16'hDEAD, 1'b0, 4'd4,  16'h9999, 4'd4,  4'd4,  16'h0044, 2'd0, 16'h0044, 2'd0, 16'd4};
        vecs[11] = '{1'b1, 1'b1, 4'd9,  16'h9999, 1'b1, 4'd9,  16'h7777, 4'd9,  4'd9,  16'h9999, 2'd2, 16'h9999, 2'd2, 16'd4};
        vecs[12] = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd9,  4'd4,  16'h7777, 2'd0, 16'h0044, 2'd0, 16'd5};
        vecs[13] = '{1'b1, 1'b1, 4'd15, 16'hABCD, 1'b1, 4'd14, 16'h1414, 4'd15, 4'd14, 16'hABCD, 2'd2, 16'h1414, 2'd1, 16'd5};
        vecs[14] = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 4'd15, 4'd14, 16'h0000, 2'd0, 16'h1414, 2'd0, 16'd6};

        resetn = 1'b0; wr_enx1 = 1'b0; dstx1 = '0; dataoutx1 = '0;
        wr_enx2 = 1'b0; dstx2 = '0; dataoutx2 = '0; rd_adrs_a = 4'd6; rd_adrs_b = 4'd11;
        #2;
        checkOutput("reset rd_data_a", -1, rd_data_a, 16'h0000);
        checkOutput("reset fwd_sel_a", -1, {14'd0, fwd_sel_a}, 16'd3);
        checkOutput("reset fwd_sel_b", -1, {14'd0, fwd_sel_b}, 16'd3);

        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #2;
            checkOutput("rd_data_a", i, rd_data_a, vecs[i].expA);
            checkOutput("fwd_sel_a", i, {14'd0, fwd_sel_a}, {14'd0, vecs[i].expSelA});
            checkOutput("rd_data_b", i, rd_data_b, vecs[i].expB);
            checkOutput("fwd_sel_b", i, {14'd0, fwd_sel_b}, {14'd0, vecs[i].expSelB});
            checkOutput("wb_count", i, wb_count, vecs[i].expCount);
        end

        // Saturation: clear, then drive the counter right up to and past its ceiling.
        @(negedge clock);
        resetn = 1'b0; wr_enx1 = 1'b0; wr_enx2 = 1'b0;
        for (int n = 0; n < 65534; n++) begin
            commitOnce(4'd1, n[15:0]);
        end
        @(negedge clock);
        wr_enx2 = 1'b0; rd_adrs_a = 4'd1;
        #2;
        checkOutput("count before ceiling", 100, wb_count, 16'hFFFE);
        checkOutput("last commit data", 100, rd_data_a, 16'hFFFD);
        commitOnce(4'd1, 16'h5A5A);
        @(negedge clock);
        wr_enx2 = 1'b0;
        #2;
        checkOutput("count at ceiling", 101, wb_count, 16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            commitOnce(4'd2, 16'h0100 + 16'(k));
            @(negedge clock);
            wr_enx2 = 1'b0; rd_adrs_a = 4'd2;
            #2;
            checkOutput("count saturated", 102 + k, wb_count, 16'hFFFF);
            checkOutput("commit past ceiling", 102 + k, rd_data_a, 16'h0100 + 16'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
